// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit. It holds the program counter, issues reads to a
// synchronous program ROM and registers each returned instruction into
// inst_reg, together with a valid flag and the address it came from.
// Jumps flush the pipeline and refill it from jump_addr. A skip request
// (for example a DECFSZ/INCFSZ result) turns the next instruction into a
// bubble. A stall freezes the whole unit.
//
// Ports
//   clk         in   1       single clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   stall       in   1       freeze fetch and inst_reg this cycle
//   jump        in   1       redirect fetch to jump_addr (single-cycle pulse)
//   jump_addr   in   ADDR_W  jump target
//   skip        in   1       discard next instruction loaded into inst_reg
//   pmem_addr   out  ADDR_W  ROM read address (registered)
//   pmem_en     out  1       ROM read enable = !stall && !rst (combinational)
//   pmem_rdata  in   INST_W  ROM data, valid 1 cycle after an enabled edge
//   inst_reg    out  INST_W  instruction to decoder
//   inst_valid  out  1       inst_reg holds a real instruction (0 = bubble)
//   inst_pc     out  ADDR_W  address of the instruction in inst_reg
//   state_dbg   out  1       current fetch state (0 = FILL, 1 = RUN)
//
// Request protocol: jump and skip are single-cycle pulses sampled on the
// rising edge. On any edge where stall is high they are ignored and the
// requester must present them again once stall drops. Within one edge the
// priority is rst > stall > jump > skip > normal advance.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                 ADDR_W       = 8,
  parameter int                 INST_W       = 8,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter logic [INST_W-1:0]  NOP_INST     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              skip,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_en,
  input  logic [INST_W-1:0] pmem_rdata,
  output logic [INST_W-1:0] inst_reg,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              state_dbg
);

  // FILL: the ROM output does not yet correspond to a wanted address (after
  //       reset or a jump), so nothing may be loaded into inst_reg.
  // RUN : pmem_rdata holds mem[fetch_pc_q] and can be consumed every edge.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q,      state_d;
  logic [ADDR_W-1:0] pmem_addr_q,  pmem_addr_d;
  logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;   // address whose data is on pmem_rdata
  logic [INST_W-1:0] inst_reg_q,   inst_reg_d;
  logic              inst_valid_q, inst_valid_d;
  logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;
  logic              skip_pend_q,  skip_pend_d;  // skip seen during FILL, applied on first RUN load

  // Next sequential fetch address; wraps silently at 2^ADDR_W.
  logic [ADDR_W-1:0] pmem_addr_inc;
  assign pmem_addr_inc = pmem_addr_q + ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    pmem_addr_d  = pmem_addr_q;
    fetch_pc_d   = fetch_pc_q;
    inst_reg_d   = inst_reg_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    skip_pend_d  = skip_pend_q;

    if (stall) begin
      // Everything holds; the ROM is disabled so its output holds too.
    end else if (state_q == FILL) begin
      if (jump) begin
        // Redirect before anything has been issued; stay in FILL.
        pmem_addr_d = jump_addr;
        skip_pend_d = 1'b0;
      end else begin
        // The ROM captures pmem_addr on this edge; remember which address
        // that was so the data can be tagged when it is consumed.
        fetch_pc_d  = pmem_addr_q;
        pmem_addr_d = pmem_addr_inc;
        state_d     = RUN;
        if (skip) begin
          skip_pend_d = 1'b1;
        end
      end
    end else begin
      if (jump) begin
        // Full flush, even when jump_addr equals the current pmem_addr: the
        // data in flight belongs to the old stream and is discarded.
        pmem_addr_d  = jump_addr;
        inst_reg_d   = NOP_INST;
        inst_valid_d = 1'b0;
        skip_pend_d  = 1'b0;
        state_d      = FILL;
      end else begin
        fetch_pc_d  = pmem_addr_q;
        pmem_addr_d = pmem_addr_inc;
        // A skipped instruction is still consumed: inst_pc advances to it so
        // the following instruction keeps its correct address.
        inst_pc_d   = fetch_pc_q;
        if (skip || skip_pend_q) begin
          inst_reg_d   = NOP_INST;
          inst_valid_d = 1'b0;
        end else begin
          inst_reg_d   = pmem_rdata;
          inst_valid_d = 1'b1;
        end
        skip_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      pmem_addr_q  <= RESET_VECTOR;
      fetch_pc_q   <= '0;
      inst_reg_q   <= NOP_INST;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      skip_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pmem_addr_q  <= pmem_addr_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_reg_q   <= inst_reg_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      skip_pend_q  <= skip_pend_d;
    end
  end

  assign pmem_addr  = pmem_addr_q;
  assign pmem_en    = !stall && !rst;
  assign inst_reg   = inst_reg_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed bench for inst_fetch with a synchronous ROM model holding
// mem[i] = i + 8'h10. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int ADDR_W = 8;
  localparam int INST_W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- DUT
  logic              stall;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              skip;
  logic [ADDR_W-1:0] pmem_addr;
  logic              pmem_en;
  logic [INST_W-1:0] pmem_rdata;
  logic [INST_W-1:0] inst_reg;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_pc;
  logic              state_dbg;

  inst_fetch #(
    .ADDR_W      (ADDR_W),
    .INST_W      (INST_W),
    .RESET_VECTOR(8'h00),
    .NOP_INST    (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .skip       (skip),
    .pmem_addr  (pmem_addr),
    .pmem_en    (pmem_en),
    .pmem_rdata (pmem_rdata),
    .inst_reg   (inst_reg),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------- ROM model
  logic [INST_W-1:0] rom [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      rom[i] = INST_W'(i + 16);
    end
  end

  always_ff @(posedge clk) begin
    if (pmem_en) begin
      pmem_rdata <= rom[pmem_addr];
    end
  end

  // ---------------------------------------------------------------- checking
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_inst(input string tag, input logic [7:0] e_inst,
                          input logic e_valid, input logic [7:0] e_pc);
    chk({tag, ".inst_reg"},   32'(inst_reg),   32'(e_inst));
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(e_valid));
    chk({tag, ".inst_pc"},    32'(inst_pc),    32'(e_pc));
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst       = 1'b1;
    stall     = 1'b0;
    jump      = 1'b0;
    jump_addr = '0;
    skip      = 1'b0;
    pmem_rdata = '0;

    // Reset state
    step();
    step();
    chk_inst("reset", 8'h00, 1'b0, 8'h00);
    chk("reset.pmem_addr", 32'(pmem_addr), 32'h00);
    chk("reset.pmem_en",   32'(pmem_en),   32'h0);
    chk("reset.state",     32'(state_dbg), 32'h0);

    // Reset release: first valid instruction on the 2nd edge
    rst = 1'b0;
    #1;
    chk("release.pmem_en", 32'(pmem_en), 32'h1);
    step();
    chk_inst("release.e1", 8'h00, 1'b0, 8'h00);
    chk("release.e1.pmem_addr", 32'(pmem_addr), 32'h01);
    chk("release.e1.state",     32'(state_dbg), 32'h1);
    step(); chk_inst("stream0", 8'h10, 1'b1, 8'h00);
    chk("stream0.pmem_addr", 32'(pmem_addr), 32'h02);
    step(); chk_inst("stream1", 8'h11, 1'b1, 8'h01);
    step(); chk_inst("stream2", 8'h12, 1'b1, 8'h02);
    step(); chk_inst("stream3", 8'h13, 1'b1, 8'h03);

    // Jump to 8'h40 while inst_pc = 3: two bubbles then mem[0x40]
    jump = 1'b1; jump_addr = 8'h40;
    step(); jump = 1'b0;
    chk_inst("jump40.b1", 8'h00, 1'b0, 8'h03);
    chk("jump40.b1.pmem_addr", 32'(pmem_addr), 32'h40);
    chk("jump40.b1.state",     32'(state_dbg), 32'h0);
    step(); chk_inst("jump40.b2", 8'h00, 1'b0, 8'h03);
    step(); chk_inst("jump40.t0", 8'h50, 1'b1, 8'h40);
    step(); chk_inst("jump40.t1", 8'h51, 1'b1, 8'h41);

    // Return to address 3 to reach inst_pc = 5 for the skip test
    jump = 1'b1; jump_addr = 8'h03;
    step(); jump = 1'b0;
    step();
    step(); chk_inst("jump3.t0", 8'h13, 1'b1, 8'h03);
    step(); chk_inst("jump3.t1", 8'h14, 1'b1, 8'h04);
    step(); chk_inst("jump3.t2", 8'h15, 1'b1, 8'h05);

    // Skip at inst_pc = 5: one bubble carrying pc 6, then pc 7 valid
    skip = 1'b1;
    step(); skip = 1'b0;
    chk_inst("skip.bubble", 8'h00, 1'b0, 8'h06);
    step(); chk_inst("skip.next", 8'h17, 1'b1, 8'h07);
    step(); chk_inst("skip.next2", 8'h18, 1'b1, 8'h08);

    // Stall held for 3 edges: everything frozen, nothing lost afterwards
    stall = 1'b1;
    #1;
    chk("stall.pmem_en", 32'(pmem_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_inst("stall.hold", 8'h18, 1'b1, 8'h08);
      chk("stall.pmem_addr", 32'(pmem_addr), 32'h0A);
    end
    stall = 1'b0;
    step(); chk_inst("stall.resume0", 8'h19, 1'b1, 8'h09);
    step(); chk_inst("stall.resume1", 8'h1A, 1'b1, 8'h0A);

    // Jump and skip in the same cycle: jump wins, no extra bubble after refill
    jump = 1'b1; jump_addr = 8'h20; skip = 1'b1;
    step(); jump = 1'b0; skip = 1'b0;
    chk_inst("jskip.b1", 8'h00, 1'b0, 8'h0A);
    step(); chk_inst("jskip.b2", 8'h00, 1'b0, 8'h0A);
    step(); chk_inst("jskip.t0", 8'h30, 1'b1, 8'h20);
    step(); chk_inst("jskip.t1", 8'h31, 1'b1, 8'h21);

    // Stall together with jump: the jump is ignored
    stall = 1'b1; jump = 1'b1; jump_addr = 8'h80;
    step(); stall = 1'b0; jump = 1'b0;
    chk_inst("stalljump.hold", 8'h31, 1'b1, 8'h21);
    chk("stalljump.pmem_addr", 32'(pmem_addr), 32'h23);
    step(); chk_inst("stalljump.next", 8'h32, 1'b1, 8'h22);

    // Skip arriving during FILL is held pending and costs one bubble
    jump = 1'b1; jump_addr = 8'h60;
    step(); jump = 1'b0;
    skip = 1'b1;
    step(); skip = 1'b0;
    chk_inst("fillskip.b2", 8'h00, 1'b0, 8'h22);
    step(); chk_inst("fillskip.bubble", 8'h00, 1'b0, 8'h60);
    step(); chk_inst("fillskip.next", 8'h71, 1'b1, 8'h61);

    // Jump to the current pmem_addr (0x63) is a full flush
    chk("selfjump.pmem_addr", 32'(pmem_addr), 32'h63);
    jump = 1'b1; jump_addr = 8'h63;
    step(); jump = 1'b0;
    chk_inst("selfjump.b1", 8'h00, 1'b0, 8'h61);
    step(); chk_inst("selfjump.b2", 8'h00, 1'b0, 8'h61);
    step(); chk_inst("selfjump.t0", 8'h73, 1'b1, 8'h63);

    // PC wrap: FE, FF, 00
    jump = 1'b1; jump_addr = 8'hFE;
    step(); jump = 1'b0;
    step();
    step(); chk_inst("wrap.fe", 8'h0E, 1'b1, 8'hFE);
    step(); chk_inst("wrap.ff", 8'h0F, 1'b1, 8'hFF);
    step(); chk_inst("wrap.00", 8'h10, 1'b1, 8'h00);

    // Reset mid-stream restarts from the reset vector
    rst = 1'b1;
    step();
    chk_inst("midrst", 8'h00, 1'b0, 8'h00);
    chk("midrst.pmem_addr", 32'(pmem_addr), 32'h00);
    rst = 1'b0;
    step(); chk_inst("midrst.e1", 8'h00, 1'b0, 8'h00);
    step(); chk_inst("midrst.e2", 8'h10, 1'b1, 8'h00);
    step(); chk_inst("midrst.e3", 8'h11, 1'b1, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
